// File: rtl/msrv_imm_gen_queue.sv
// RISC-V immediate generator feeding a small result FIFO.
// Each pushed request stores its decoded immediate and tag; the head is shown on the outputs while valid.
module msrv_imm_gen_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       flush_in,
  input  logic                       in_valid_in,
  output logic                       in_ready_out,
  input  logic [31:7]                instr_in,
  input  logic [2:0]                 imm_type_in,
  input  logic [TAG_W-1:0]           tag_in,
  output logic                       out_valid_out,
  input  logic                       out_ready_in,
  output logic [XLEN-1:0]            imm_out,
  output logic [TAG_W-1:0]           tag_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Immediates are built at 64 bits with instr[31] replicated, then truncated to XLEN.
  function automatic logic [XLEN-1:0] decode_imm(input logic [31:7] ins, input logic [2:0] t);
    logic [63:0] w;
    logic [31:0] s;
    s = {32{ins[31]}};
    case (t)
      3'b000, 3'b001: w = {s, s[19:0], ins[31:20]};
      3'b010:         w = {s, s[19:0], ins[31:25], ins[11:7]};
      3'b011:         w = {s, s[18:0], ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b100:         w = {s, ins[31:12], 12'h000};
      3'b101:         w = {s, s[10:0], ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b110:         w = {59'd0, ins[19:15]};
      3'b111:         w = (XLEN == 64) ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
      default:        w = 64'd0;
    endcase
    return w[XLEN-1:0];
  endfunction

  logic [XLEN-1:0]  imm_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;
  logic [XLEN-1:0]  imm_s;

  assign in_ready_out  = (count_q < DEPTH_C);
  assign out_valid_out = (count_q != {CW{1'b0}});
  assign push_s        = in_valid_in && in_ready_out;
  assign pop_s         = out_valid_out && out_ready_in;
  assign imm_s         = decode_imm(instr_in, imm_type_in);
  assign count_out     = count_q;
  assign imm_out       = out_valid_out ? imm_mem_q[rd_ptr_q] : {XLEN{1'b0}};
  assign tag_out       = out_valid_out ? tag_mem_q[rd_ptr_q] : {TAG_W{1'b0}};

  // Next pointer and occupancy; flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; count of zero hides any stale storage.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, left unreset.
  always_ff @(posedge clk_in) begin
    if (push_s && !flush_in) begin
      imm_mem_q[wr_ptr_q] <= imm_s;
      tag_mem_q[wr_ptr_q] <= tag_in;
    end
  end

endmodule

// File: tb/tb_msrv_imm_gen_queue.sv
// Directed bench: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_msrv_imm_gen_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] ins = 32'd0;
  logic [2:0]  itype = 3'd0;
  logic [3:0]  tag = 4'd0;

  logic        rdy32, vld32, rdy64, vld64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [3:0]  tag32, tag64;
  logic [2:0]  cnt32, cnt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv_imm_gen_queue #(.XLEN(32), .DEPTH(4), .TAG_W(4)) u32 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .in_valid_in(in_valid),
    .in_ready_out(rdy32), .instr_in(ins[31:7]), .imm_type_in(itype), .tag_in(tag),
    .out_valid_out(vld32), .out_ready_in(out_ready), .imm_out(imm32), .tag_out(tag32),
    .count_out(cnt32));

  msrv_imm_gen_queue #(.XLEN(64), .DEPTH(4), .TAG_W(4)) u64 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .in_valid_in(in_valid),
    .in_ready_out(rdy64), .instr_in(ins[31:7]), .imm_type_in(itype), .tag_in(tag),
    .out_valid_out(vld64), .out_ready_in(out_ready), .imm_out(imm64), .tag_out(tag64),
    .count_out(cnt64));

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one request with nothing queued, check both widths next cycle, then pop it.
  task automatic decode_case(input string name, input logic [31:0] i, input logic [2:0] t,
                             input logic [31:0] e32, input logic [63:0] e64);
    ins = i; itype = t; tag = 4'hA; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check({name, "_v32"}, {63'd0, vld32}, 64'd1);
    check({name, "_imm32"}, {32'd0, imm32}, {32'd0, e32});
    check({name, "_imm64"}, imm64, e64);
    check({name, "_tag64"}, {60'd0, tag64}, 64'hA);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_empty"}, {61'd0, cnt64}, 64'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_cnt", {61'd0, cnt32}, 64'd0);
    check("rst_vld", {63'd0, vld32}, 64'd0);
    check("rst_imm", {32'd0, imm32}, 64'd0);
    check("rst_tag", {60'd0, tag32}, 64'd0);
    check("rst_rdy", {63'd0, rdy32}, 64'd1);
    check("rst_rdy64", {63'd0, rdy64}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic I-type push, latency one cycle
    ins = 32'hFFF00093; itype = 3'b000; tag = 4'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("i_vld", {63'd0, vld32}, 64'd1);
    check("i_imm", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
    check("i_tag", {60'd0, tag32}, 64'd3);
    check("i_cnt", {61'd0, cnt32}, 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("i_pop_cnt", {61'd0, cnt32}, 64'd0);
    check("i_pop_vld", {63'd0, vld32}, 64'd0);
    check("i_pop_imm", {32'd0, imm32}, 64'd0);

    // Decode table
    decode_case("i1",  32'h7FF00013, 3'b001, 32'h0000_07FF, 64'h0000_0000_0000_07FF);
    decode_case("s",   32'hFE112E23, 3'b010, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    decode_case("b",   32'h00000463, 3'b011, 32'h0000_0008, 64'h0000_0000_0000_0008);
    decode_case("bn",  32'hFE000FE3, 3'b011, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE);
    decode_case("u",   32'h12345037, 3'b100, 32'h1234_5000, 64'h0000_0000_1234_5000);
    decode_case("u80", 32'h80000037, 3'b100, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    decode_case("j",   32'h8000006F, 3'b101, 32'hFFF0_0000, 64'hFFFF_FFFF_FFF0_0000);
    decode_case("csr", 32'h800F8073, 3'b110, 32'h0000_001F, 64'h0000_0000_0000_001F);
    decode_case("sh",  32'h03F00013, 3'b111, 32'h0000_001F, 64'h0000_0000_0000_003F);

    // Fill with consumer stalled; the fifth push is dropped
    itype = 3'b100; out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      ins = {20'(k), 12'h037}; tag = 4'(k);
      if (k == 5) check("full_rdy_pre", {63'd0, rdy32}, 64'd0);
      tick();
    end
    in_valid = 1'b0;
    check("full_cnt", {61'd0, cnt32}, 64'd4);
    check("full_rdy", {63'd0, rdy32}, 64'd0);
    check("stall_imm", {32'd0, imm32}, 64'h0000_1000);
    tick();
    check("stall_hold", {32'd0, imm32}, 64'h0000_1000);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_imm", {32'd0, imm32}, {32'd0, 20'(k), 12'h000});
      check("drain_tag", {60'd0, tag32}, 64'(k));
      tick();
    end
    out_ready = 1'b0;
    check("drain_cnt", {61'd0, cnt32}, 64'd0);
    check("drain_vld", {63'd0, vld32}, 64'd0);

    // Steady push and pop across several pointer wraps
    ins = {20'd0, 12'h037}; tag = 4'd0; in_valid = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      ins = {20'(i), 12'h037}; tag = 4'(i);
      tick();
      check("steady_cnt", {61'd0, cnt32}, 64'd1);
      check("steady_imm", {32'd0, imm32}, {32'd0, 20'(i), 12'h000});
      check("steady_tag", {60'd0, tag32}, 64'(i));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("steady_end", {61'd0, cnt32}, 64'd0);

    // Flush with a concurrent push while three entries are held
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("pre_flush_cnt", {61'd0, cnt32}, 64'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_cnt", {61'd0, cnt32}, 64'd0);
    check("flush_vld", {63'd0, vld32}, 64'd0);
    check("flush_imm", {32'd0, imm32}, 64'd0);

    // Push into empty queue with consumer ready: no same-cycle pop
    ins = 32'hFFF00093; itype = 3'b000; tag = 4'd7;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bypass_cnt", {61'd0, cnt32}, 64'd1);
    check("bypass_tag", {60'd0, tag32}, 64'd7);
    tick();
    out_ready = 1'b0;
    check("bypass_pop", {61'd0, cnt32}, 64'd0);

    // Asynchronous reset mid-cycle with two entries queued
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("prerst_cnt", {61'd0, cnt32}, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cnt", {61'd0, cnt32}, 64'd0);
    check("arst_vld", {63'd0, vld32}, 64'd0);
    check("arst_imm", {32'd0, imm32}, 64'd0);
    check("arst_tag", {60'd0, tag32}, 64'd0);
    check("arst_rdy", {63'd0, rdy32}, 64'd1);
    check("arst_imm64", imm64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ins = 32'h12345037; itype = 3'b100; tag = 4'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("resume_cnt", {61'd0, cnt32}, 64'd1);
    check("resume_imm", {32'd0, imm32}, 64'h1234_5000);
    check("resume_tag", {60'd0, tag32}, 64'd9);
    check("resume_v64", {63'd0, vld64}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
